ber_phase_scan_ctrl: RTL
========================

BER_PHASE_SCAN_CTRL -- requirements
Module: ber_phase_scan_ctrl

Interface
REQ-001 Parameter BER_W, default 4: width of the BER and delay result buses from the BER checker.
REQ-002 Parameter VALID_DIV, default 4: o_valid strobe period in clk cycles (2..255).
REQ-003 Parameter TIMEOUT, default 4096: maximum RUN cycles per phase (1..65535).
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 i_start  in  1  one-cycle pulse; begins a scan of all four phases.
REQ-007 i_done  in  1  BER checker adaptation finished; results valid while high.
REQ-008 i_min_ber  in  BER_W  minimum error count reported by the checker.
REQ-009 i_min_delay  in  BER_W  delay index at which i_min_ber occurred.
REQ-010 o_enable  out  1  BER checker enable.
REQ-011 o_phase  out  2  sampling phase applied to the receiver and checker.
REQ-012 o_valid  out  1  sample strobe for the checker, high one cycle in every VALID_DIV cycles while o_enable is high.
REQ-013 o_best_phase / o_best_delay / o_best_ber  out  2 / BER_W / BER_W  locked result.
REQ-014 o_lock  out  1  high while the locked phase has o_best_ber == 0.
REQ-015 o_busy  out  1  high in every state except IDLE and LOCK.

Function
REQ-016 FSM states: IDLE, ARM, RUN, EVAL, APPLY, LOCK.
REQ-017 IDLE: o_enable=0. i_start -> ARM with phase counter=0, best_ber=all ones, best_valid=0.
REQ-018 ARM lasts exactly one cycle: o_phase=phase counter, o_enable=0, giving the checker a rising enable edge on the next cycle.
REQ-019 RUN: o_enable=1; timeout counter increments each cycle; i_done=1 -> EVAL; timeout counter == TIMEOUT-1 without i_done -> EVAL with the phase marked failed.
REQ-020 EVAL lasts one cycle: a non-failed phase replaces the best when i_min_ber < best_ber (strict, so ties keep the lower phase); the phase, delay and ber are captured and best_valid is set.
REQ-021 From EVAL: phase counter < 3 -> increment, ARM; phase counter == 3 -> APPLY.
REQ-022 APPLY lasts one cycle: o_phase=best phase, o_enable=0, then LOCK; if best_valid=0, go to IDLE and hold best outputs at their reset values.
REQ-023 LOCK: o_enable=1 on the best phase, o_best_* stable; o_lock = (o_best_ber == 0).
REQ-024 i_start in any state other than IDLE or LOCK is ignored; i_start in LOCK restarts the scan (-> ARM, phase 0).
REQ-025 o_valid divider resets to 0 whenever o_enable is 0; the first strobe comes VALID_DIV cycles after o_enable rises.
REQ-026 o_phase changes only in ARM or APPLY, never while o_enable=1.
REQ-027 i_done and timeout in the same RUN cycle: i_done wins and the phase is not failed.
REQ-028 i_min_ber is compared unsigned at full BER_W; an all-ones value still qualifies if the phase did not fail.

Reset
REQ-029 rst low asynchronously forces IDLE, o_enable=0, o_valid=0, o_phase=0, o_best_phase=0, o_best_delay=0, o_best_ber=all ones, o_lock=0, o_busy=0, and clears all counters.
REQ-030 Reset asserted mid-scan discards partial results; no scan resumes after release without a new i_start.

Structure
REQ-031 A shared package holds the FSM state encoding, the PHASE_W=2 and NUM_PHASES=4 constants, and the BER_W default shared with the BER checker.
REQ-032 The o_valid divider is one sub-module, valid_strobe_gen (enable, period, strobe out).

Verification
REQ-033 i_done after 100 RUN cycles per phase with min_ber 5,2,7,3 -> o_best_phase=1, o_best_ber=2, LOCK, o_lock=0.
REQ-034 Phases 0 and 2 both report min_ber 0 -> o_best_phase=0 (tie keeps lower phase), o_lock=1.
REQ-035 i_done never asserted, TIMEOUT=16 -> each RUN lasts exactly 16 cycles, then APPLY -> IDLE, o_lock=0, o_best_ber all ones.
REQ-036 VALID_DIV=4 -> o_valid high on cycles 4, 8, 12 after o_enable rises; low in ARM and APPLY; o_phase stable while o_enable=1.
REQ-037 rst pulsed low during the RUN of phase 2 -> all outputs take reset values at once; a new i_start rescans from phase 0.
REQ-038 i_done coincident with the timeout cycle -> phase evaluated normally; i_start mid-scan has no effect.

Source files
------------

// File: rtl/ber_phase_scan_ctrl_pkg.sv
// rtl/ber_phase_scan_ctrl_pkg.sv - shared constants and FSM encoding for the BER phase scan controller
package ber_phase_scan_ctrl_pkg;

    localparam int PHASE_W       = 2;
    localparam int NUM_PHASES    = 4;
    localparam int BER_W_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_EVAL,
        ST_APPLY,
        ST_LOCK
    } state_e;

endpackage

// File: rtl/ber_phase_scan_ctrl_valid_strobe_gen.sv
// rtl/ber_phase_scan_ctrl_valid_strobe_gen.sv - one-cycle strobe every period_i cycles while enabled
module valid_strobe_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic [7:0] period_i,
    output logic       strobe_o
);

    logic [7:0] cnt_q, cnt_d;
    logic       strobe_q, strobe_d;
    logic       wrap;

    assign wrap = (cnt_q == period_i - 8'd1);

    always_comb begin
        cnt_d    = '0;
        strobe_d = 1'b0;
        if (enable_i) begin
            cnt_d    = wrap ? 8'd0 : cnt_q + 8'd1;
            strobe_d = wrap;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
        end
    end

    // Gate with the live enable so a strobe registered on the last enabled cycle never leaks out.
    assign strobe_o = strobe_q & enable_i;

endmodule

// File: rtl/ber_phase_scan_ctrl.sv
// rtl/ber_phase_scan_ctrl.sv - scans four sampling phases against a BER checker and locks on the best one
module ber_phase_scan_ctrl
    import ber_phase_scan_ctrl_pkg::*;
#(
    parameter int BER_W     = BER_W_DEFAULT,
    parameter int VALID_DIV = 4,
    parameter int TIMEOUT   = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_done,
    input  logic [BER_W-1:0]   i_min_ber,
    input  logic [BER_W-1:0]   i_min_delay,
    output logic               o_enable,
    output logic [PHASE_W-1:0] o_phase,
    output logic               o_valid,
    output logic [PHASE_W-1:0] o_best_phase,
    output logic [BER_W-1:0]   o_best_delay,
    output logic [BER_W-1:0]   o_best_ber,
    output logic               o_lock,
    output logic               o_busy
);

    localparam logic [15:0]        TMO_LAST   = 16'(TIMEOUT - 1);
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
    localparam logic [7:0]         DIV        = 8'(VALID_DIV);

    state_e             state_q;
    logic [PHASE_W-1:0] phase_cnt_q;
    logic [15:0]        tmo_cnt_q;
    logic               enable_q;
    logic [PHASE_W-1:0] phase_q;
    logic               busy_q;
    logic               lock_q;

    logic               failed_q;
    logic [BER_W-1:0]   cap_ber_q;
    logic [BER_W-1:0]   cap_delay_q;

    logic               best_valid_q;
    logic [PHASE_W-1:0] best_phase_q;
    logic [BER_W-1:0]   best_delay_q;
    logic [BER_W-1:0]   best_ber_q;

    logic [PHASE_W-1:0] pub_phase_q;
    logic [BER_W-1:0]   pub_delay_q;
    logic [BER_W-1:0]   pub_ber_q;

    logic               start_scan;
    logic               eval_take;

    assign start_scan = i_start && (state_q == ST_IDLE || state_q == ST_LOCK);
    // First passing phase always qualifies, even with an all-ones error count.
    assign eval_take  = !failed_q && (!best_valid_q || cap_ber_q < best_ber_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            phase_cnt_q  <= '0;
            tmo_cnt_q    <= '0;
            enable_q     <= 1'b0;
            phase_q      <= '0;
            busy_q       <= 1'b0;
            lock_q       <= 1'b0;
            failed_q     <= 1'b0;
            cap_ber_q    <= '0;
            cap_delay_q  <= '0;
            best_valid_q <= 1'b0;
            best_phase_q <= '0;
            best_delay_q <= '0;
            best_ber_q   <= '1;
            pub_phase_q  <= '0;
            pub_delay_q  <= '0;
            pub_ber_q    <= '1;
        end else if (start_scan) begin
            state_q      <= ST_ARM;
            phase_cnt_q  <= '0;
            phase_q      <= '0;
            enable_q     <= 1'b0;
            busy_q       <= 1'b1;
            lock_q       <= 1'b0;
            best_valid_q <= 1'b0;
            best_phase_q <= '0;
            best_delay_q <= '0;
            best_ber_q   <= '1;
        end else begin
            case (state_q)
                ST_ARM: begin
                    state_q   <= ST_RUN;
                    enable_q  <= 1'b1;
                    tmo_cnt_q <= '0;
                end
                ST_RUN: begin
                    tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    if (i_done) begin
                        state_q     <= ST_EVAL;
                        enable_q    <= 1'b0;
                        failed_q    <= 1'b0;
                        cap_ber_q   <= i_min_ber;
                        cap_delay_q <= i_min_delay;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        state_q  <= ST_EVAL;
                        enable_q <= 1'b0;
                        failed_q <= 1'b1;
                    end
                end
                ST_EVAL: begin
                    if (eval_take) begin
                        best_valid_q <= 1'b1;
                        best_phase_q <= phase_cnt_q;
                        best_delay_q <= cap_delay_q;
                        best_ber_q   <= cap_ber_q;
                    end
                    if (phase_cnt_q == LAST_PHASE) begin
                        state_q <= ST_APPLY;
                        phase_q <= eval_take ? phase_cnt_q : best_phase_q;
                    end else begin
                        state_q     <= ST_ARM;
                        phase_cnt_q <= phase_cnt_q + PHASE_W'(1);
                        phase_q     <= phase_cnt_q + PHASE_W'(1);
                    end
                end
                ST_APPLY: begin
                    busy_q <= 1'b0;
                    if (best_valid_q) begin
                        state_q     <= ST_LOCK;
                        enable_q    <= 1'b1;
                        pub_phase_q <= best_phase_q;
                        pub_delay_q <= best_delay_q;
                        pub_ber_q   <= best_ber_q;
                        lock_q      <= (best_ber_q == '0);
                    end else begin
                        state_q     <= ST_IDLE;
                        pub_phase_q <= '0;
                        pub_delay_q <= '0;
                        pub_ber_q   <= '1;
                        lock_q      <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    valid_strobe_gen u_valid_strobe_gen (
        .clk      (clk),
        .rst      (rst),
        .enable_i (enable_q),
        .period_i (DIV),
        .strobe_o (o_valid)
    );

    assign o_enable     = enable_q;
    assign o_phase      = phase_q;
    assign o_best_phase = pub_phase_q;
    assign o_best_delay = pub_delay_q;
    assign o_best_ber   = pub_ber_q;
    assign o_lock       = lock_q;
    assign o_busy       = busy_q;

endmodule
